// File: rtl/sine_dds_pkg.sv
// Shared types and defaults for the sine DDS sequencer.
package sine_dds_pkg;

    localparam int unsigned DEF_AW       = 8;
    localparam int unsigned DEF_DW       = 8;
    localparam int unsigned DEF_PW       = 16;
    localparam int unsigned DRAIN_CYCLES = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPlay  = 2'd1,
        StDrain = 2'd2
    } state_t;

endpackage

// File: rtl/sine_phase_acc.sv
// Phase accumulator with load and enable.
// Presents the top AW bits of the phase as the table address.
module sine_phase_acc
    import sine_dds_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned PW = DEF_PW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [PW-1:0] i_load_val,
    input  logic          i_en,
    input  logic [PW-1:0] i_step,
    output logic [AW-1:0] o_addr
);

    logic [PW-1:0] r_phase;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase <= '0;
        end else if (i_load) begin
            r_phase <= i_load_val;
        end else if (i_en) begin
            r_phase <= r_phase + i_step;
        end
    end

    assign o_addr = r_phase[PW-1 -: AW];

endmodule

// File: rtl/sine_dds_sequencer.sv
// Sequences a single-port sine RAM: table loading in IDLE, phase-swept playback in PLAY,
// and a two-stage read pipeline that turns RAM output into a valid-tagged sample stream.
module sine_dds_sequencer
    import sine_dds_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned PW = DEF_PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [PW-1:0] ftw,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_qout,
    output logic [DW-1:0] sample,
    output logic          sample_valid,
    output logic          busy
);

    state_t        r_state;
    state_t        w_state_d;
    logic [1:0]    r_drain_cnt;
    logic [1:0]    w_drain_cnt_d;
    logic [PW-1:0] r_ftw_q;
    logic [AW-1:0] r_ram_addr;
    logic          r_ram_we;
    logic [DW-1:0] r_ram_din;
    logic          r_rd_vld;
    logic          r_rd_vld_d;
    logic [DW-1:0] r_sample;
    logic          r_sample_valid;

    logic          w_wr_acc;
    logic          w_start_acc;
    logic          w_acc_en;
    logic [AW-1:0] w_phase_addr;

    assign wr_ready = (r_state == StIdle) && !rst;

    always_comb begin
        w_state_d     = r_state;
        w_drain_cnt_d = r_drain_cnt;
        w_wr_acc      = 1'b0;
        w_start_acc   = 1'b0;
        w_acc_en      = 1'b0;
        unique case (r_state)
            StIdle: begin
                // A write handshake beats start; stop vetoes a simultaneous start.
                if (wr_valid && wr_ready) begin
                    w_wr_acc = 1'b1;
                end else if (start && !stop) begin
                    w_start_acc = 1'b1;
                    w_state_d   = StPlay;
                end
            end
            StPlay: begin
                if (stop) begin
                    w_state_d     = StDrain;
                    w_drain_cnt_d = 2'd0;
                end else begin
                    w_acc_en = 1'b1;
                end
            end
            StDrain: begin
                if (r_drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                    w_state_d = StIdle;
                end else begin
                    w_drain_cnt_d = r_drain_cnt + 2'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_drain_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_d;
            r_drain_cnt <= w_drain_cnt_d;
        end
    end

    sine_phase_acc #(
        .AW(AW),
        .PW(PW)
    ) u_phase_acc (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_start_acc),
        .i_load_val (ftw),
        .i_en       (w_acc_en),
        .i_step     (r_ftw_q),
        .o_addr     (w_phase_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ftw_q        <= '0;
            r_ram_addr     <= '0;
            r_ram_we       <= 1'b0;
            r_ram_din      <= '0;
            r_rd_vld       <= 1'b0;
            r_rd_vld_d     <= 1'b0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_ram_we   <= w_wr_acc;
            r_rd_vld   <= w_start_acc || w_acc_en;
            r_rd_vld_d <= r_rd_vld;
            if (w_wr_acc) begin
                r_ram_addr <= wr_addr;
                r_ram_din  <= wr_data;
            end else if (w_start_acc) begin
                r_ram_addr <= '0;
            end else if (w_acc_en) begin
                r_ram_addr <= w_phase_addr;
            end
            if (w_start_acc) begin
                r_ftw_q <= ftw;
            end
            // RAM output lags the address by one cycle; sample it when that read was valid.
            if (r_rd_vld_d) begin
                r_sample <= ram_qout;
            end
            r_sample_valid <= r_rd_vld_d;
        end
    end

    assign ram_addr     = r_ram_addr;
    assign ram_we       = r_ram_we;
    assign ram_din      = r_ram_din;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign busy         = (r_state != StIdle);

endmodule

// File: tb/tb_sine_dds_sequencer.sv
// Self-checking bench for sine_dds_sequencer with a behavioural read-first sine RAM.
module tb_sine_dds_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] ftw;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  ram_qout;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        busy;

    int n_checks;
    int n_errors;

    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];

    typedef struct {
        logic       wr_valid;
        logic [7:0] wr_addr;
        logic [7:0] wr_data;
        logic       start;
        logic       stop;
        logic       exp_ready;
        logic       exp_we;
        logic       exp_busy;
        logic [7:0] exp_addr;
        logic [7:0] exp_din;
    } vec_t;

    vec_t vecs [9];

    sine_dds_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .ftw          (ftw),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_din      (ram_din),
        .ram_qout     (ram_qout),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_qout <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] addr_of(input logic [15:0] f, input int k);
        logic [31:0] p;
        p = 32'(k) * 32'(f);
        return p[15:8];
    endfunction

    // Start a run at tuning word f, stop while the n-th address is presented, then drain.
    task automatic run_play(input logic [15:0] f, input int n);
        int pulses;
        pulses   = 0;
        wr_valid = 1'b0;
        ftw      = f;
        start    = 1'b1;
        step();
        start    = 1'b0;
        ftw      = ~f;
        wr_valid = 1'b1;
        wr_addr  = 8'h00;
        wr_data  = 8'hee;
        for (int k = 0; k < n; k++) begin
            chk("play_addr", 32'(ram_addr), 32'(addr_of(f, k)));
            chk("play_busy", 32'(busy), 32'd1);
            chk("play_we", 32'(ram_we), 32'd0);
            chk("play_ready", 32'(wr_ready), 32'd0);
            if (sample_valid) pulses++;
            if (k >= 2) begin
                chk("play_sv", 32'(sample_valid), 32'd1);
                chk("play_sample", 32'(sample), 32'(exp_mem[addr_of(f, k - 2)]));
            end else begin
                chk("play_sv_lead", 32'(sample_valid), 32'd0);
            end
            if (k == n - 1) begin
                stop     = 1'b1;
                wr_valid = 1'b0;
            end
            step();
        end
        stop = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("drain_busy", 32'(busy), 32'd1);
            chk("drain_addr_hold", 32'(ram_addr), 32'(addr_of(f, n - 1)));
            chk("drain_sv", 32'(sample_valid), 32'd1);
            chk("drain_sample", 32'(sample), 32'(exp_mem[addr_of(f, n - 2 + d)]));
            if (sample_valid) pulses++;
            step();
        end
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_sv", 32'(sample_valid), 32'd0);
        chk("idle_ready", 32'(wr_ready), 32'd1);
        chk("pulse_count", 32'(pulses), 32'(n));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            exp_mem[i] = 8'h00;
        end
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        ftw      = 16'h0100;
        wr_valid = 1'b0;
        wr_addr  = 8'h00;
        wr_data  = 8'h00;

        //          wv  addr   data   st  sp  rdy we  busy eaddr  edin
        vecs[0] = '{1'b1, 8'h01, 8'h10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 8'h10};
        vecs[1] = '{1'b1, 8'h03, 8'h30, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 8'h30};
        vecs[2] = '{1'b1, 8'h06, 8'h60, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h06, 8'h60};
        vecs[3] = '{1'b1, 8'h0a, 8'ha0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0a, 8'ha0};
        vecs[4] = '{1'b1, 8'h0f, 8'hf0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0f, 8'hf0};
        vecs[5] = '{1'b0, 8'h44, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0f, 8'hf0};
        vecs[6] = '{1'b1, 8'h20, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 8'h55};
        vecs[7] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h20, 8'h55};
        vecs[8] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 8'h55};

        step();
        chk("rst_ready", 32'(wr_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_din", 32'(ram_din), 32'd0);
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_sv", 32'(sample_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_release_ready", 32'(wr_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            wr_valid = vecs[i].wr_valid;
            wr_addr  = vecs[i].wr_addr;
            wr_data  = vecs[i].wr_data;
            start    = vecs[i].start;
            stop     = vecs[i].stop;
            chk("vec_ready_pre", 32'(wr_ready), 32'd1);
            step();
            if (vecs[i].wr_valid && vecs[i].exp_we) exp_mem[vecs[i].wr_addr] = vecs[i].wr_data;
            chk("vec_ready", 32'(wr_ready), 32'(vecs[i].exp_ready));
            chk("vec_we", 32'(ram_we), 32'(vecs[i].exp_we));
            chk("vec_busy", 32'(busy), 32'(vecs[i].exp_busy));
            chk("vec_addr", 32'(ram_addr), 32'(vecs[i].exp_addr));
            chk("vec_din", 32'(ram_din), 32'(vecs[i].exp_din));
        end
        wr_valid = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        step();

        run_play(16'h0100, 20);
        run_play(16'h0080, 10);
        run_play(16'h8000, 6);
        run_play(16'h0000, 4);
        run_play(16'h0100, 10);
        chk("readback_01", 32'(mem[8'h01]), 32'h10);
        chk("readback_0f", 32'(mem[8'h0f]), 32'hf0);

        ftw   = 16'h0100;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk("mrst_sv", 32'(sample_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_we", 32'(ram_we), 32'd0);
        chk("mrst_addr", 32'(ram_addr), 32'd0);
        chk("mrst_ready", 32'(wr_ready), 32'd0);
        rst = 1'b0;
        step();
        chk("mrst_sv2", 32'(sample_valid), 32'd0);
        chk("mrst_ready2", 32'(wr_ready), 32'd1);
        run_play(16'h0100, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
